// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Samples a multiplexed seven-segment DIG/SEG scan stream and
//               rebuilds the four displayed hex digits, blank flags and
//               decimal points. A frame is published only after it has been
//               seen identically STABLE_FRAMES times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int SETTLE         = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT        = 65535,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [3:0]  DIG,
    input  logic [7:0]  SEG,
    output logic [15:0] digit,
    output logic [3:0]  blank,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        seg_err,
    output logic        scan_err,
    output logic        no_signal
);

    localparam int            TW            = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TIMEOUT     = TW'(TIMEOUT);
    localparam logic [3:0]    C_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2:0]    C_STABLE      = 3'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Conditioned inputs, always active-high
    logic [3:0]  dig_q;
    logic [7:0]  seg_q;

    // Scan FSM and working frame
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  pos_q;
    logic [3:0]  captured_q;
    logic [15:0] wval_q, wval_d;
    logic [3:0]  wblk_q, wblk_d;
    logic [3:0]  wdp_q,  wdp_d;

    // Candidate pipeline and stability history ({value, blank, dp})
    logic [23:0] cand_q;
    logic        cand_v_q;
    logic [23:0] hist_q;
    logic        hist_v_q;
    logic [2:0]  match_q;
    logic        pub_once_q;
    logic [TW-1:0] tcnt_q;

    logic [3:0]  dec_val;
    logic        dec_blank;
    logic        dec_legal;
    logic        multi_hot;
    logic        one_hot;
    logic [3:0]  sel;
    logic [1:0]  enc;
    logic        capture;
    logic [3:0]  captured_next;
    logic        complete;
    logic        same;
    logic [2:0]  match_d;
    logic        publish;
    logic [TW-1:0] tcnt_inc;

    assign multi_hot     = |(dig_q & (dig_q - 4'd1));
    assign one_hot       = (dig_q != 4'd0) && !multi_hot;
    assign sel           = 4'b0001 << pos_q;
    assign enc           = {dig_q[3] | dig_q[2], dig_q[3] | dig_q[1]};
    assign capture       = (state_q == S_SETTLE) && !multi_hot && (dig_q == sel)
                           && (cnt_q == C_SETTLE_LAST) && dec_legal;
    assign captured_next = captured_q | sel;
    assign complete      = capture && (captured_next == 4'hF);

    // Register and polarity-normalise the scan inputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dig_q <= 4'd0;
            seg_q <= 8'd0;
        end else begin
            dig_q <= DIG_ACTIVE_LOW ? ~DIG : DIG;
            seg_q <= SEG_ACTIVE_LOW ? ~SEG : SEG;
        end
    end

    // Map the a..g pattern to a hex value; all-off is a dark position
    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_legal = 1'b1;
        case (seg_q[6:0])
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Working frame with the position being captured this cycle merged in
    always_comb begin
        wval_d = wval_q;
        wblk_d = wblk_q;
        wdp_d  = wdp_q;
        if (capture) begin
            wval_d[{pos_q, 2'b00} +: 4] = dec_val;
            wblk_d[pos_q]               = dec_blank;
            wdp_d[pos_q]                = seg_q[7];
        end
    end

    // Scan FSM: latch a position, wait SETTLE cycles, sample once, hold
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            pos_q      <= 2'd0;
            captured_q <= 4'd0;
            wval_q     <= 16'd0;
            wblk_q     <= 4'd0;
            wdp_q      <= 4'd0;
            cand_q     <= 24'd0;
            cand_v_q   <= 1'b0;
            seg_err    <= 1'b0;
            scan_err   <= 1'b0;
        end else begin
            seg_err  <= 1'b0;
            scan_err <= 1'b0;
            cand_v_q <= complete;
            wval_q   <= wval_d;
            wblk_q   <= wblk_d;
            wdp_q    <= wdp_d;
            if (complete) begin
                cand_q <= {wval_d, wblk_d, wdp_d};
            end
            if (multi_hot) begin
                scan_err   <= 1'b1;
                captured_q <= 4'd0;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (one_hot) begin
                            state_q <= S_SETTLE;
                            cnt_q   <= 4'd0;
                            pos_q   <= enc;
                        end
                    end
                    S_SETTLE: begin
                        if (dig_q != sel) begin
                            state_q <= S_IDLE;
                        end else if (cnt_q == C_SETTLE_LAST) begin
                            state_q <= S_HOLD;
                            if (dec_legal) begin
                                captured_q <= complete ? 4'd0 : captured_next;
                            end else begin
                                seg_err <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    S_HOLD: begin
                        if (dig_q != sel) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign same    = hist_v_q && (cand_q == hist_q);
    assign match_d = same ? ((match_q >= C_STABLE) ? C_STABLE : match_q + 3'd1) : 3'd1;
    // A saturated run that sees the same candidate again must not republish
    assign publish = cand_v_q && (match_d == C_STABLE) && !(same && (match_q == C_STABLE));

    // Stability tracking and publication of the displayed frame
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hist_q        <= 24'd0;
            hist_v_q      <= 1'b0;
            match_q       <= 3'd0;
            pub_once_q    <= 1'b0;
            digit         <= 16'd0;
            blank         <= 4'hF;
            dp            <= 4'd0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            if (cand_v_q) begin
                hist_q   <= cand_q;
                hist_v_q <= 1'b1;
                match_q  <= match_d;
            end
            if (publish) begin
                digit         <= cand_q[23:8];
                blank         <= cand_q[7:4];
                dp            <= cand_q[3:0];
                frame_valid   <= 1'b1;
                frame_changed <= !pub_once_q || (cand_q != {digit, blank, dp});
                pub_once_q    <= 1'b1;
            end
        end
    end

    assign tcnt_inc = (tcnt_q == C_TIMEOUT) ? tcnt_q : tcnt_q + TW'(1);

    // Loss-of-signal timer, cleared by every complete candidate
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tcnt_q    <= '0;
            no_signal <= 1'b1;
        end else if (complete) begin
            tcnt_q    <= '0;
            no_signal <= 1'b0;
        end else begin
            tcnt_q <= tcnt_inc;
            if (tcnt_inc == C_TIMEOUT) begin
                no_signal <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Self-checking bench for seg7_scan_capture. Drives active-low
//               scan frames; expected publications go into a scoreboard queue
//               and are compared whenever frame_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int P_SETTLE  = 4;
    localparam int P_STABLE  = 2;
    localparam int P_TIMEOUT = 1000;
    localparam int DWELL     = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  DIG = 4'hF;
    logic [7:0]  SEG = 8'hFF;
    logic [15:0] digit;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_changed;
    logic        seg_err;
    logic        scan_err;
    logic        no_signal;

    seg7_scan_capture #(
        .SETTLE         (P_SETTLE),
        .STABLE_FRAMES  (P_STABLE),
        .TIMEOUT        (P_TIMEOUT),
        .DIG_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_in        (clk),
        .reset         (rst),
        .DIG           (DIG),
        .SEG           (SEG),
        .digit         (digit),
        .blank         (blank),
        .dp            (dp),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .seg_err       (seg_err),
        .scan_err      (scan_err),
        .no_signal     (no_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
        logic        chg;
    } exp_t;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  blk;
        logic [3:0]  dpm;
        int          nfr;
        bit          pub;
        bit          chg;
    } vec_t;

    exp_t        sb[$];
    vec_t        rows[8];
    logic [6:0]  glyph[16];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_seg_err  = 0;
    int          n_scan_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mask_blank(input logic [15:0] v, input logic [3:0] b);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*4 +: 4] = 4'h0;
        end
        return r;
    endfunction

    // Monitor: count error pulses and score every publication
    always @(negedge clk) begin
        if (!rst) begin
            if (seg_err)  n_seg_err++;
            if (scan_err) n_scan_err++;
            if (frame_changed) check("changed_implies_valid", {31'd0, frame_valid}, 32'd1);
            if (frame_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_publish: digit=%h blank=%b dp=%b, expected no publish",
                             digit, blank, dp);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pub_digit", {16'd0, digit}, {16'd0, e.d});
                    check("pub_blank", {28'd0, blank}, {28'd0, e.b});
                    check("pub_dp", {28'd0, dp}, {28'd0, e.p});
                    check("pub_changed", {31'd0, frame_changed}, {31'd0, e.chg});
                end
            end
        end
    end

    task automatic scan_pos(input int i, input logic [15:0] v, input logic [3:0] b,
                            input logic [3:0] p, input bit bad, input int dwell);
        logic [6:0] g;
        logic [3:0] oh;
        g  = b[i] ? 7'h00 : glyph[v[i*4 +: 4]];
        if (bad) g = 7'h01;
        oh = 4'b0001 << i;
        DIG = ~oh;
        SEG = ~{p[i], g};
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input logic [15:0] v, input logic [3:0] b, input logic [3:0] p,
                              input bit bad0, input int dwell);
        for (int i = 3; i >= 0; i--) begin
            scan_pos(i, v, b, p, bad0 && (i == 0), dwell);
        end
    endtask

    task automatic go_idle(input int n);
        DIG = 4'hF;
        SEG = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t r, input string tag);
        exp_t e;
        if (r.pub) begin
            e.d   = mask_blank(r.val, r.blk);
            e.b   = r.blk;
            e.p   = r.dpm;
            e.chg = r.chg;
            sb.push_back(e);
        end
        for (int f = 0; f < r.nfr; f++) scan_frame(r.val, r.blk, r.dpm, 1'b0, DWELL);
        check({tag, "_pending"}, sb.size(), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   base_a;
        int   base_b;

        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;

        //            value     blank    dp       frames pub   chg
        rows[0] = '{16'h1234, 4'b0000, 4'b0100, 2, 1'b1, 1'b1};
        rows[1] = '{16'h1234, 4'b0000, 4'b0100, 3, 1'b0, 1'b0};
        rows[2] = '{16'h1235, 4'b0000, 4'b0100, 2, 1'b1, 1'b1};
        rows[3] = '{16'h0945, 4'b1000, 4'b0000, 2, 1'b1, 1'b1};
        rows[4] = '{16'hABCD, 4'b0000, 4'b1001, 2, 1'b1, 1'b1};
        rows[5] = '{16'hEF07, 4'b0000, 4'b0000, 1, 1'b0, 1'b0};
        rows[6] = '{16'hABCD, 4'b0000, 4'b1001, 2, 1'b1, 1'b0};
        rows[7] = '{16'h0000, 4'b1111, 4'b0000, 2, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit", {16'd0, digit}, 32'h0);
        check("rst_blank", {28'd0, blank}, 32'hF);
        check("rst_dp", {28'd0, dp}, 32'h0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_no_signal", {31'd0, no_signal}, 32'd1);
        rst = 1'b0;
        go_idle(4);
        check("post_rst_no_signal", {31'd0, no_signal}, 32'd1);

        // Dwell shorter than the settle time never captures
        for (int f = 0; f < 3; f++) scan_frame(16'h1234, 4'b0000, 4'b0100, 1'b0, 3);
        check("short_dwell_no_signal", {31'd0, no_signal}, 32'd1);
        check("short_dwell_digit", {16'd0, digit}, 32'h0);

        // Table rows: publish, no republish, change, dark position
        for (int r = 0; r < 4; r++) run_row(rows[r], $sformatf("row%0d", r));
        check("scanning_no_signal", {31'd0, no_signal}, 32'd0);

        // Multi-hot glitch after a partial scan; stale partial must not leak
        base_a = n_scan_err;
        scan_pos(1, 16'h9999, 4'b0000, 4'b0000, 1'b0, DWELL);
        scan_pos(0, 16'h9999, 4'b0000, 4'b0000, 1'b0, DWELL);
        DIG = ~4'b0011;
        @(posedge clk);
        #1;
        go_idle(10);
        check("scan_err_pulses", n_scan_err - base_a, 32'd1);
        e.d = 16'h5678; e.b = 4'b0000; e.p = 4'b0010; e.chg = 1'b1;
        sb.push_back(e);
        scan_frame(16'h5678, 4'b0000, 4'b0010, 1'b0, DWELL);
        check("scan_err_one_frame_pending", sb.size(), 32'd1);
        scan_frame(16'h5678, 4'b0000, 4'b0010, 1'b0, DWELL);
        check("scan_err_two_frames_pending", sb.size(), 32'd0);

        // Illegal glyph on pos0: flagged every frame, never published
        base_a = n_seg_err;
        for (int f = 0; f < 3; f++) scan_frame(16'h9ABC, 4'b0000, 4'b0000, 1'b1, DWELL);
        check("seg_err_pulses", n_seg_err - base_a, 32'd3);
        check("seg_err_digit_hold", {16'd0, digit}, 32'h5678);
        base_b = n_scan_err;
        DIG = ~4'b1010;
        @(posedge clk);
        #1;
        go_idle(4);
        check("realign_scan_err", n_scan_err - base_b, 32'd1);
        check("before_timeout_no_signal", {31'd0, no_signal}, 32'd0);

        // Loss of signal, then recovery on the first complete frame
        go_idle(P_TIMEOUT + 5);
        check("timeout_no_signal", {31'd0, no_signal}, 32'd1);
        check("timeout_digit_hold", {16'd0, digit}, 32'h5678);
        check("timeout_dp_hold", {28'd0, dp}, 32'b0010);
        scan_frame(16'h5678, 4'b0000, 4'b0010, 1'b0, DWELL);
        check("resume_no_signal", {31'd0, no_signal}, 32'd0);
        check("resume_no_publish", sb.size(), 32'd0);

        // Glyph coverage and a republish of the frame already displayed
        for (int r = 4; r < 7; r++) run_row(rows[r], $sformatf("row%0d", r));

        // Asynchronous reset while the FSM is settling
        DIG = ~4'b0001;
        SEG = ~{1'b0, glyph[1]};
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_digit", {16'd0, digit}, 32'h0);
        check("async_rst_blank", {28'd0, blank}, 32'hF);
        check("async_rst_dp", {28'd0, dp}, 32'h0);
        check("async_rst_no_signal", {31'd0, no_signal}, 32'd1);
        check("async_rst_valid", {31'd0, frame_valid}, 32'd0);
        go_idle(3);
        rst = 1'b0;
        go_idle(4);

        // First publish after reset reports a change even when it matches reset outputs
        run_row(rows[7], "row7");

        go_idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver: samples the DIG/SEG scan stream and reconstructs the four displayed digits, blank flags and decimal points.
- Used in FPGA self-check and loopback of the clock display, and as a bench monitor for display drivers.
- Requires a stable, repeated scan before publishing a frame; flags malformed scans and loss of signal.

Parameters:
- SETTLE, 4, clk_in cycles after a select change before SEG is sampled (1..15)
- STABLE_FRAMES, 2, consecutive identical complete frames required before publishing (1..7)
- TIMEOUT, 65535, clk_in cycles without a complete frame before no_signal asserts
- DIG_ACTIVE_LOW, 1, DIG polarity; 1 means a low bit selects that digit
- SEG_ACTIVE_LOW, 1, SEG polarity; 1 means a low bit lights that segment

Ports:
- clk_in  in  1  system clock; same domain as the display driver
- reset  in  1  asynchronous, active-high reset
- DIG  in  4  digit select from the driver; bit i selects position i
- SEG  in  8  segments: [0]=a … [6]=g, [7]=dp
- digit  out  16  captured hex value; position i in [4i+3:4i]
- blank  out  4  position i was dark (a..g all off)
- dp  out  4  decimal point state per position
- frame_valid  out  1  one-cycle pulse when a stable frame is published
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the published frame differs from the previous one
- seg_err  out  1  one-cycle pulse: sampled a..g pattern is not a legal glyph
- scan_err  out  1  one-cycle pulse: DIG had more than one position selected
- no_signal  out  1  level: no complete frame seen within TIMEOUT cycles

Behaviour:
- Input conditioning:
  - DIG and SEG are registered once.
  - Polarity is normalised to active-high internally.
  - All logic below uses these registered values.
- Decode (active-high a..g):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - 00 → blank=1, value 0.
  - Any other pattern → seg_err pulse; that position is treated as not captured.
- Scan FSM, states IDLE, SETTLE, HOLD:
  - IDLE: DIG one-hot → SETTLE with cnt=0 and the position latched. DIG=0 stays in IDLE.
  - SETTLE: cnt increments each cycle while DIG equals the latched one-hot value.
    - When cnt reaches SETTLE-1, sample SEG, decode, set captured[pos], store value/blank/dp into the working frame, then go to HOLD.
    - If DIG changes before sampling, return to IDLE without capturing.
  - HOLD: wait for DIG to differ from the latched value, then go to IDLE. The same cycle's new value is evaluated in IDLE on the next cycle.
- Multi-hot DIG, any state: scan_err pulse, captured cleared, FSM to IDLE.
- Frame assembly:
  - When captured becomes 4'b1111, the working frame is a candidate and captured clears.
  - Candidate equal to the previous candidate → match count increments, saturating at STABLE_FRAMES. Otherwise match count = 1.
  - When match count reaches STABLE_FRAMES, publish: outputs update and frame_valid pulses in the cycle after the candidate completes.
  - Publish at most once per stability run; a further identical candidate does not re-publish.
  - frame_changed = published frame differs from the outputs it replaces. It is 1 on the first publish after reset.
- Timeout:
  - A counter increments every cycle and clears on each complete candidate.
  - no_signal=1 when the count reaches TIMEOUT; cleared by the next complete candidate.
  - The counter saturates and does not wrap.
- Simultaneous events: a candidate completing on the same cycle as the timeout threshold clears the count, so no_signal stays 0.
- Outputs retain the last published frame during errors and no_signal.
- Reset, asynchronous, at any time:
  - digit=0, blank=4'hF, dp=0.
  - All pulses 0, no_signal=1.
  - FSM IDLE, captured=0, match count=0, candidate history invalid.
  - A partially captured frame is discarded.

Test Plan:
- Active-low scan of 1,2,3,4 (pos3..0) with 64-cycle dwell, dp on pos2 → after the 2nd identical frame, frame_valid and frame_changed pulse; digit=16'h1234, dp=4'b0100, blank=0.
- Keep scanning 1234 for 3 more frames → no further frame_valid. Change pos0 to 5 → after 2 frames, digit=16'h1235, frame_valid=1, frame_changed=1.
- Hour-tens dark (SEG a..g off on pos3), 0945 → digit=16'h0945, blank=4'b1000.
- Dwell shorter than SETTLE (3 cycles, SETTLE=4) → no capture, no frame_valid, no_signal stays 1.
- DIG=4'b0011 active-high for one cycle mid-frame → scan_err pulse, partial frame discarded; publish occurs 2 full frames later. Illegal pattern 0x01 → seg_err, that frame is not published.
- Stop scanning (DIG idle) for TIMEOUT+1 cycles → no_signal=1, digit retained. Resume → no_signal clears on the first complete frame. Assert reset mid-SETTLE → all outputs at reset values within the same cycle.
